ram_port_master: RTL and testbench

- Request-side initiator for the team's single-port synchronous RAM (write-or-read per cycle, 1-cycle registered read, dout held on write cycles).
- After reset, fills every RAM location with INIT_VALUE.
- Then accepts read/write commands on a valid/ready interface and drives the RAM port.
- Returns read data on a separate valid/ready response interface, buffered in an internal FIFO so the consumer can apply backpressure.

---
 rtl/ram_port_master_if.sv | 27 ++
 rtl/ram_port_master.sv | 96 +++++++++
 tb/tb_ram_port_master.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_master_if.sv
// Command/response bundle for ram_port_master.
//   req_*  : command channel (valid/ready), write when req_we=1, else read
//   rsp_*  : read-data channel (valid/ready), data returned in command order
// master = command issuer / response consumer, slave = ram_port_master.
interface ram_port_master_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_din;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_din, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_din, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/ram_port_master.sv
// Request-side initiator for a single-port synchronous RAM (1-cycle registered
// read, dout held on write cycles).
// After reset the whole RAM is swept with INIT_VALUE, then commands from the
// bus are forwarded to the RAM port and read data is returned through a small
// response FIFO so the consumer can stall.
// Ports:
//   clk, rst   : clock shared with the RAM, synchronous active-high reset
//   bus        : slave side of command/response channels
//   init_busy  : high while the init sweep runs
//   ram_we/ram_addr/ram_din/ram_dout : RAM port
module ram_port_master #(
  parameter int                   DATA_WIDTH = 8,
  parameter int                   ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  parameter int                   RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_port_master_if.slave      bus,
  output logic                  init_busy,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);
  localparam int PW = $clog2(RSP_DEPTH);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  rd_inflight;
  logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW:0]           fifo_cnt;
  logic [PW+1:0]         occ;
  logic                  accept, rd_accept, push, pop;

  // Occupancy counts the read already in the RAM pipe, so every accepted read
  // is guaranteed a FIFO slot and overflow cannot happen.
  assign occ           = {1'b0, fifo_cnt} + {{(PW+1){1'b0}}, rd_inflight};
  assign init_busy     = (state == S_INIT);
  assign bus.req_ready = (state == S_RUN) && (occ < (PW+2)'(RSP_DEPTH));
  assign accept        = bus.req_valid && bus.req_ready;
  assign rd_accept     = accept && !bus.req_we;

  // dout is valid the cycle after the read was accepted; push it then.
  assign push          = rd_inflight;
  assign pop           = bus.rsp_valid && bus.rsp_ready;
  assign bus.rsp_valid = (fifo_cnt != '0);
  assign bus.rsp_data  = fifo_mem[rd_ptr];

  // In RUN the RAM port follows the request directly; only we is qualified.
  // Address/data toggling without an accept is harmless: the RAM just
  // refreshes dout, which is ignored unless a read is in flight.
  always_comb begin
    if (state == S_INIT) begin
      ram_we   = 1'b1;
      ram_addr = init_cnt;
      ram_din  = INIT_VALUE;
    end else begin
      ram_we   = accept && bus.req_we;
      ram_addr = bus.req_addr;
      ram_din  = bus.req_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_INIT;
      init_cnt    <= '0;
      rd_inflight <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
    end else begin
      if (state == S_INIT) begin
        init_cnt <= init_cnt + ADDR_WIDTH'(1);
        if (&init_cnt) state <= S_RUN;
      end
      rd_inflight <= rd_accept;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Storage needs no reset; pointers/count define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && push) fifo_mem[wr_ptr] <= ram_dout;
  end
endmodule

// File: tb/tb_ram_port_master.sv
module tb_ram_port_master;
  logic       clk, rst;
  logic       init_busy, ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_din, ram_dout;
  logic [7:0] mem [16];
  int         n_vec, n_err, cyc;
  logic [7:0] rq [$];
  int         rc [$];
  logic       rnd_en;

  ram_port_master_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  ram_port_master #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .INIT_VALUE(8'hA5), .RSP_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .init_busy(init_busy),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM model: write or read per cycle, dout held on writes.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    else        ram_dout      <= mem[ram_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.rsp_valid && bus.rsp_ready) begin
      rq.push_back(bus.rsp_data);
      rc.push_back(cyc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    if (rnd_en) bus.rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) nxt();
  endtask

  task automatic send(input logic we, input logic [3:0] a, input logic [7:0] d);
    int n;
    n = 0;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a; bus.req_din = d;
    smp();
    while (!bus.req_ready && n < 100) begin
      nxt(); smp(); n++;
    end
    if (!bus.req_ready) chk("send_timeout", 32'(bus.req_ready), 1);
    nxt();
    bus.req_valid = 1'b0;
  endtask

  // Called at the start of the first INIT cycle; req_valid is held high to
  // show it is ignored during the sweep.
  task automatic sweep();
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 4'h7; bus.req_din = 8'h00;
    for (int i = 0; i < 16; i++) begin
      smp();
      chk("sweep_busy", 32'(init_busy), 1);
      chk("sweep_we", 32'(ram_we), 1);
      chk("sweep_addr", 32'(ram_addr), 32'(i));
      chk("sweep_din", 32'(ram_din), 32'hA5);
      chk("sweep_ready", 32'(bus.req_ready), 0);
      chk("sweep_rsp_valid", 32'(bus.rsp_valid), 0);
      nxt();
    end
    bus.req_valid = 1'b0;
    smp();
    chk("run_busy", 32'(init_busy), 0);
    chk("run_ready", 32'(bus.req_ready), 1);
    chk("run_we", 32'(ram_we), 0);
    nxt();
  endtask

  initial begin
    logic [7:0] md [8];
    md = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    n_vec = 0; n_err = 0; rnd_en = 1'b0;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_din = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    nxt(); nxt(); smp();
    chk("rst_busy", 32'(init_busy), 1);
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_we", 32'(ram_we), 1);
    chk("rst_addr", 32'(ram_addr), 0);
    chk("rst_din", 32'(ram_din), 32'hA5);
    nxt();
    rst = 1'b0;
    sweep();

    // Read back the whole RAM: all INIT_VALUE, in order
    bus.rsp_ready = 1'b1;
    rq.delete(); rc.delete();
    for (int i = 0; i < 16; i++) send(1'b0, 4'(i), 8'h00);
    wait_cyc(5);
    chk("init_rd_count", 32'(rq.size()), 16);
    for (int i = 0; i < 16; i++)
      if (i < rq.size()) chk("init_rd_data", 32'(rq[i]), 32'hA5);

    // Write then read same address next cycle: rsp_valid first at N+3
    bus.rsp_ready = 1'b0;
    rq.delete(); rc.delete();
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 4'h3; bus.req_din = 8'h5C;
    smp();
    chk("wtr_ready", 32'(bus.req_ready), 1);
    chk("wtr_ram_we", 32'(ram_we), 1);
    nxt();
    bus.req_we = 1'b0;
    smp();
    chk("wtr_rd_ram_we", 32'(ram_we), 0);
    chk("wtr_valid_n1", 32'(bus.rsp_valid), 0);
    nxt();
    bus.req_valid = 1'b0;
    smp();
    chk("wtr_valid_n2", 32'(bus.rsp_valid), 0);
    nxt(); smp();
    chk("wtr_valid_n3", 32'(bus.rsp_valid), 1);
    chk("wtr_data", 32'(bus.rsp_data), 32'h5C);
    nxt();
    bus.rsp_ready = 1'b1;
    nxt();
    bus.rsp_ready = 1'b0;
    smp();
    chk("wtr_drained", 32'(bus.rsp_valid), 0);
    nxt();

    // Streaming reads of addr i = i*3
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(1'b1, 4'(i), 8'(i * 3));
    rq.delete(); rc.delete();
    bus.req_valid = 1'b1; bus.req_we = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.req_addr = 4'(i);
      smp();
      chk("stream_ready", 32'(bus.req_ready), 1);
      nxt();
    end
    bus.req_valid = 1'b0;
    wait_cyc(4);
    chk("stream_count", 32'(rq.size()), 16);
    for (int i = 0; i < 16; i++)
      if (i < rq.size()) begin
        chk("stream_data", 32'(rq[i]), 32'(i * 3));
        chk("stream_cycle", 32'(rc[i] - rc[0]), 32'(i));
      end

    // Backpressure: exactly 4 reads accepted with rsp_ready low
    bus.rsp_ready = 1'b0;
    rq.delete(); rc.delete();
    bus.req_valid = 1'b1; bus.req_we = 1'b0;
    for (int c = 0; c < 8; c++) begin
      bus.req_addr = 4'(c);
      smp();
      chk("bp_ready", 32'(bus.req_ready), (c < 4) ? 1 : 0);
      nxt();
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_cyc(6);
    chk("bp_count", 32'(rq.size()), 4);
    for (int i = 0; i < 4; i++)
      if (i < rq.size()) chk("bp_data", 32'(rq[i]), 32'(i * 3));
    smp();
    chk("bp_resume", 32'(bus.req_ready), 1);
    nxt();

    // Mixed write/read to addr 5 with random rsp_ready
    rq.delete(); rc.delete();
    rnd_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      send(1'b1, 4'h5, md[k]);
      send(1'b0, 4'h5, 8'h00);
    end
    rnd_en = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_cyc(10);
    chk("mix_count", 32'(rq.size()), 8);
    for (int k = 0; k < 8; k++)
      if (k < rq.size()) chk("mix_data", 32'(rq[k]), 32'(md[k]));

    // Reset with 3 queued responses and 1 read in flight
    bus.rsp_ready = 1'b0;
    rq.delete(); rc.delete();
    for (int k = 0; k < 4; k++) send(1'b0, 4'(k), 8'h00);
    rst = 1'b1;
    smp();
    chk("mid_pre_valid", 32'(bus.rsp_valid), 1);
    chk("mid_pre_ready", 32'(bus.req_ready), 0);
    nxt();
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    sweep();
    wait_cyc(4);
    chk("mid_no_stale", 32'(rq.size()), 0);
    send(1'b0, 4'h5, 8'h00);
    wait_cyc(4);
    chk("mid_reinit_count", 32'(rq.size()), 1);
    if (rq.size() > 0) chk("mid_reinit_data", 32'(rq[0]), 32'hA5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
